sram_delay_line: RTL

- Circular-buffer delay controller sitting directly upstream of the SRAM interface stage.
- Accepts 16-bit audio samples over a valid/ready handshake.
- For each sample, reads back the sample written DELAY samples earlier, then writes the new sample. Each 16-bit sample is stored as two byte-wide SRAM transactions.
- Emits the delayed sample downstream to the effects/mix stage.

---
 rtl/sram_delay_line_if.sv | 29 ++
 rtl/sram_delay_line.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sram_delay_line_if.sv
// Stream and SRAM-port bundle for sram_delay_line.
// slave: the delay controller itself; master: the surrounding pipeline and SRAM stage.
interface sram_delay_line_if #(
  parameter int ADDR_W   = 19,
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] in_sample;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-2:0]   delay;
  logic [SAMPLE_W-1:0] out_sample;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_data;
  logic                wr_ena;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;

  modport slave (
    input  in_sample, in_valid, delay, out_ready, rd_data,
    output in_ready, out_sample, out_valid, rd_addr, wr_ena, wr_addr, wr_data
  );

  modport master (
    output in_sample, in_valid, delay, out_ready, rd_data,
    input  in_ready, out_sample, out_valid, rd_addr, wr_ena, wr_addr, wr_data
  );
endinterface

// File: rtl/sram_delay_line.sv
// Circular-buffer audio delay controller in front of a byte-wide SRAM.
// Per sample: read the two bytes written 'delay' samples ago, write the new
// sample's two bytes, then present the delayed sample downstream.
// Optional build macro DELAY_ZERO_FILL_EN: outputs zero for reads reaching
// beyond the number of samples written since reset.
module sram_delay_line #(
  parameter int ADDR_W   = 19,
  parameter int SAMPLE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_delay_line_if.slave  bus
);

  localparam int PTR_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr_c;
  logic [SAMPLE_W-1:0] sample_q;
  logic                bypass_q;
  logic                zero_q;
  logic [SAMPLE_W-1:0] out_sample_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;

  assign rd_ptr_c = wr_ptr - bus.delay;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: fixed five-step walk, then wait in OUT for downstream
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = RD_LO;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = WR_LO;
      WR_LO:   state_nxt = WR_HI;
      WR_HI:   state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; wr_ena follows the async-reset state directly
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.wr_ena    = (state == WR_LO) || (state == WR_HI);
    bus.out_valid = (state == OUT);
  end

  assign bus.out_sample = out_sample_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

  // Datapath: SRAM addresses are registered one step ahead so each is
  // stable for the whole cycle of the state it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      sample_q     <= '0;
      bypass_q     <= 1'b0;
      out_sample_q <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sample_q  <= bus.in_sample;
            bypass_q  <= (bus.delay == '0);
            rd_addr_q <= {rd_ptr_c, 1'b0};
          end
        end
        RD_LO: begin
          rd_addr_q[0] <= 1'b1;
        end
        RD_HI: begin
          out_sample_q[7:0] <= bus.rd_data;
          wr_addr_q         <= {wr_ptr, 1'b0};
          wr_data_q         <= sample_q[7:0];
        end
        WR_LO: begin
          out_sample_q[SAMPLE_W-1:8] <= bus.rd_data;
          wr_addr_q                  <= {wr_ptr, 1'b1};
          wr_data_q                  <= sample_q[SAMPLE_W-1:8];
        end
        WR_HI: begin
          if (bypass_q)    out_sample_q <= sample_q;
          else if (zero_q) out_sample_q <= '0;
        end
        OUT: begin
          if (bus.out_ready) wr_ptr <= wr_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DELAY_ZERO_FILL_EN
  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(1) << PTR_W;

  logic [ADDR_W-1:0] fill_cnt;

  // Written-sample count (saturating) and the per-sample "not yet written" flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid)
        zero_q <= ({1'b0, bus.delay} > fill_cnt);
      if (state == WR_HI && fill_cnt != FILL_MAX)
        fill_cnt <= fill_cnt + ADDR_W'(1);
    end
  end
`else
  assign zero_q = 1'b0;
`endif

endmodule
